// File: rtl/regwrite_queue_if.sv
// Bundle of the producer handshakes, register-file write port and hazard query
// seen by regwrite_queue. The queue uses the slave side.
interface regwrite_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          AluValid;
  logic [AW-1:0] AluAddr;
  logic [DW-1:0] AluData;
  logic          AluReady;
  logic          MemValid;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemData;
  logic          MemReady;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;
  logic          RegWrite;
  logic [AW-1:0] QueryReg;
  logic          QueryPending;
  logic [CW-1:0] Count;

  modport master (
    output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, QueryReg,
    input  AluReady, MemReady, WriteRegister, WriteData, RegWrite, QueryPending, Count
  );

  modport slave (
    input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, QueryReg,
    output AluReady, MemReady, WriteRegister, WriteData, RegWrite, QueryPending, Count
  );
endinterface

// File: rtl/regwrite_queue.sv
// In-order write queue in front of the register file's single write port:
// merges ALU and load writebacks (load first) and drains one entry per cycle.
module regwrite_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  regwrite_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    addrMem [DEPTH];
  logic [DW-1:0]    dataMem [DEPTH];
  logic [DEPTH-1:0] validVec;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    aluSlot;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic             memTake;
  logic             aluTake;
  logic             pop;
  logic             pending;

  // free comes from the registered count only; a same-cycle pop never frees a slot.
  always_comb begin
    free         = FULL - count;
    bus.MemReady = !Reset && (free >= CW'(1));
    memTake      = bus.MemValid && bus.MemReady && (bus.MemAddr != '0);
    bus.AluReady = !Reset && (free >= (memTake ? CW'(2) : CW'(1)));
    aluTake      = bus.AluValid && bus.AluReady && (bus.AluAddr != '0);
    pop          = !Reset && (count != '0);
    aluSlot      = wrPtr + PW'(memTake);
  end

  assign bus.WriteRegister = addrMem[rdPtr];
  assign bus.WriteData     = dataMem[rdPtr];
  assign bus.RegWrite      = pop;
  assign bus.Count         = count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      validVec <= '0;
      // NOTE: storage is reset on purpose so the head outputs read 0 after reset;
      // this forces flops rather than RAM, which is fine at this depth.
      for (int i = 0; i < DEPTH; i++) begin
        addrMem[i] <= '0;
        dataMem[i] <= '0;
      end
    end else begin
      if (pop) begin
        validVec[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + PW'(1);
      end
      if (memTake) begin
        addrMem[wrPtr]  <= bus.MemAddr;
        dataMem[wrPtr]  <= bus.MemData;
        validVec[wrPtr] <= 1'b1;
      end
      if (aluTake) begin
        addrMem[aluSlot]  <= bus.AluAddr;
        dataMem[aluSlot]  <= bus.AluData;
        validVec[aluSlot] <= 1'b1;
      end
      wrPtr <= wrPtr + PW'(memTake) + PW'(aluTake);
      count <= count + CW'(memTake) + CW'(aluTake) - CW'(pop);
    end
  end

  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validVec[i] && (addrMem[i] == bus.QueryReg)) pending = 1'b1;
    end
  end

  assign bus.QueryPending = pending && (bus.QueryReg != '0);
endmodule
